// File: rtl/mac_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_fifo_pkg
// Purpose  : Shared constants, entry layout and sizing helper for the MAC TX
//            FIFO (framer -> PCS/encoder side).
// Contents : N_CHANNELS, W_BYTE, MAC_TX_FIFO_DEPTH defaults,
//            W_MAC_TX_FIFO_ENTRY, mac_tx_fifo_entry_t,
//            mac_tx_fifo_entry_w() for non-default lane configurations.
// Revision : 1.0 - initial release
// ============================================================================
package mac_tx_fifo_pkg;

  localparam int unsigned N_CHANNELS        = 4;
  localparam int unsigned W_BYTE            = 8;
  localparam int unsigned MAC_TX_FIFO_DEPTH = 16;

  // One stored entry: end-of-frame tag, per-lane ctrl bits, lane data.
  localparam int unsigned W_MAC_TX_FIFO_ENTRY = N_CHANNELS * (W_BYTE + 1) + 1;

  typedef struct packed {
    logic                           last;
    logic [N_CHANNELS-1:0]          ctrl;
    logic [N_CHANNELS*W_BYTE-1:0]   data;
  } mac_tx_fifo_entry_t;

  // Entry width for an arbitrary lane configuration; same packing order as
  // mac_tx_fifo_entry_t ({last, ctrl, data}).
  function automatic int unsigned mac_tx_fifo_entry_w(input int unsigned n_ch,
                                                      input int unsigned w_lane);
    return n_ch * (w_lane + 1) + 1;
  endfunction

endpackage : mac_tx_fifo_pkg
`default_nettype wire

// File: rtl/mac_tx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_fifo_mem
// Purpose  : DEPTH x W simple dual-port register array for the MAC TX FIFO.
//            Synchronous write, asynchronous (combinational) read so the
//            FIFO head can be presented fall-through. Contents are not reset.
// Ports    : i_clk    - clock
//            i_wen    - write enable (already qualified by the caller)
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address
//            o_rdata  - read data, combinational from the array
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 37
) (
  input  logic                     i_clk,
  input  logic                     i_wen,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : mac_tx_fifo_mem
`default_nettype wire

// File: rtl/mac_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_fifo
// Purpose  : Frame-aware TX FIFO between the MAC TX framer and the PCS side.
//            Each entry holds N_CH lanes of {ctrl, byte} plus an end-of-frame
//            tag. Reports full/almost-full/level, sticky overflow/underflow
//            and the number of complete frames stored. With STORE_FWD=1 the
//            reader only sees committed (complete) frames and an open partial
//            frame can be discarded with i_wdrop.
// Ports    : i_clk, i_reset (async, active high), i_clk_en (gates all state)
//            i_clr               - synchronous flush
//            i_wen/i_wlast/i_wdrop/i_wctrl/i_wdata - write side
//            o_full, o_afull     - write-side flow control
//            i_ren               - read request
//            o_rctrl/o_rdata/o_rlast/o_empty - fall-through head entry
//            o_level, o_frames   - occupancy in entries / complete frames
//            o_ovf, o_udf        - sticky overflow / underflow
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_fifo
  import mac_tx_fifo_pkg::*;
#(
  parameter int unsigned N_CH      = N_CHANNELS,
  parameter int unsigned W_LANE    = W_BYTE,
  parameter int unsigned DEPTH     = MAC_TX_FIFO_DEPTH,
  parameter int unsigned AFULL_THR = DEPTH - 4,
  parameter bit          STORE_FWD = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clk_en,
  input  logic                     i_clr,
  input  logic                     i_wen,
  input  logic                     i_wlast,
  input  logic                     i_wdrop,
  input  logic [N_CH-1:0]          i_wctrl,
  input  logic [N_CH*W_LANE-1:0]   i_wdata,
  output logic                     o_full,
  output logic                     o_afull,
  input  logic                     i_ren,
  output logic [N_CH-1:0]          o_rctrl,
  output logic [N_CH*W_LANE-1:0]   o_rdata,
  output logic                     o_rlast,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_frames,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam int unsigned c_pw = c_aw + 1;
  localparam int unsigned c_ew = mac_tx_fifo_entry_w(N_CH, W_LANE);

  localparam logic [c_pw-1:0] c_ptr_one   = c_pw'(1);
  localparam logic [c_pw-1:0] c_afull_thr = c_pw'(AFULL_THR);

  // Pointers carry one extra wrap bit above the address bits.
  logic [c_pw-1:0] r_wptr;    // raw write pointer
  logic [c_pw-1:0] r_cptr;    // committed pointer: start of the open frame
  logic [c_pw-1:0] r_rptr;    // read pointer
  logic [c_pw-1:0] r_frames;
  logic            r_ovf;
  logic            r_udf;

  logic [c_pw-1:0] w_vptr;
  logic [c_pw-1:0] w_level;
  logic            w_empty;
  logic            w_full;
  logic            w_drop;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_ovf_set;
  logic            w_udf_set;
  logic            w_frm_inc;
  logic            w_frm_dec;
  logic [c_ew-1:0] w_wentry;
  logic [c_ew-1:0] w_rentry;

  // In store-and-forward mode the reader is bounded by the committed pointer,
  // so a partially written frame stays invisible until its last entry lands.
  assign w_vptr  = STORE_FWD ? r_cptr : r_wptr;
  assign w_empty = (w_vptr == r_rptr);
  assign w_full  = (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]) &&
                   (r_wptr[c_aw] != r_rptr[c_aw]);
  assign w_level = r_wptr - r_rptr;

  // Drop outranks a same-cycle write; both are void under a flush. The
  // memory write enable carries the full qualification, including i_clk_en.
  assign w_drop    = i_wdrop & STORE_FWD;
  assign w_wr_ok   = i_clk_en & ~i_clr & ~w_drop & i_wen & ~w_full;
  assign w_rd_ok   = i_ren & ~w_empty;
  assign w_ovf_set = ~w_drop & i_wen & w_full;
  assign w_udf_set = i_ren & w_empty;
  assign w_frm_inc = w_wr_ok & i_wlast;
  assign w_frm_dec = w_rd_ok & o_rlast;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr   <= '0;
      r_cptr   <= '0;
      r_rptr   <= '0;
      r_frames <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (i_clk_en) begin
      if (i_clr) begin
        r_wptr   <= '0;
        r_cptr   <= '0;
        r_rptr   <= '0;
        r_frames <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (w_drop) begin
          r_wptr <= r_cptr;
        end else if (w_wr_ok) begin
          r_wptr <= r_wptr + c_ptr_one;
          if (i_wlast) begin
            r_cptr <= r_wptr + c_ptr_one;
          end
        end
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end

        if (w_rd_ok) begin
          r_rptr <= r_rptr + c_ptr_one;
        end
        if (w_udf_set) begin
          r_udf <= 1'b1;
        end

        // A frame completing and a frame leaving in the same cycle cancel.
        case ({w_frm_inc, w_frm_dec})
          2'b10:   r_frames <= r_frames + c_ptr_one;
          2'b01:   r_frames <= r_frames - c_ptr_one;
          default: r_frames <= r_frames;
        endcase
      end
    end
  end

  assign w_wentry = {i_wlast, i_wctrl, i_wdata};

  mac_tx_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (c_ew)
  ) u_mem (
    .i_clk   (i_clk),
    .i_wen   (w_wr_ok),
    .i_waddr (r_wptr[c_aw-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (r_rptr[c_aw-1:0]),
    .o_rdata (w_rentry)
  );

  assign o_rlast  = w_rentry[c_ew-1];
  assign o_rctrl  = w_rentry[c_ew-2 -: N_CH];
  assign o_rdata  = w_rentry[N_CH*W_LANE-1:0];

  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_afull  = (w_level >= c_afull_thr);
  assign o_level  = w_level;
  assign o_frames = r_frames;
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;

endmodule : mac_tx_fifo
`default_nettype wire

// File: tb/tb_mac_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx_fifo
// Purpose  : Self-checking bench for mac_tx_fifo. Two instances (STORE_FWD=0
//            and STORE_FWD=1, DEPTH=16) share one stimulus stream; each is
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tx_fifo;

  localparam int DEPTH = 16;
  typedef logic [36:0] ent_t;   // {last, ctrl[3:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst, clk_en, clr, wen, wlast, wdrop, ren;
  logic [3:0]  wctrl;
  logic [31:0] wdata;

  logic        s_full [2];
  logic        s_afull[2];
  logic        s_empty[2];
  logic        s_rlast[2];
  logic        s_ovf  [2];
  logic        s_udf  [2];
  logic [3:0]  s_rctrl[2];
  logic [31:0] s_rdata[2];
  logic [4:0]  s_level[2];
  logic [4:0]  s_frames[2];

  always #5 clk = ~clk;

  mac_tx_fifo #(.DEPTH(DEPTH), .STORE_FWD(1'b0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_clr(clr),
    .i_wen(wen), .i_wlast(wlast), .i_wdrop(wdrop), .i_wctrl(wctrl),
    .i_wdata(wdata), .o_full(s_full[0]), .o_afull(s_afull[0]),
    .i_ren(ren), .o_rctrl(s_rctrl[0]), .o_rdata(s_rdata[0]),
    .o_rlast(s_rlast[0]), .o_empty(s_empty[0]), .o_level(s_level[0]),
    .o_frames(s_frames[0]), .o_ovf(s_ovf[0]), .o_udf(s_udf[0])
  );

  mac_tx_fifo #(.DEPTH(DEPTH), .STORE_FWD(1'b1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_clr(clr),
    .i_wen(wen), .i_wlast(wlast), .i_wdrop(wdrop), .i_wctrl(wctrl),
    .i_wdata(wdata), .o_full(s_full[1]), .o_afull(s_afull[1]),
    .i_ren(ren), .o_rctrl(s_rctrl[1]), .o_rdata(s_rdata[1]),
    .o_rlast(s_rlast[1]), .o_empty(s_empty[1]), .o_level(s_level[1]),
    .o_frames(s_frames[1]), .o_ovf(s_ovf[1]), .o_udf(s_udf[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stored entries as a queue, the length of the open
  // (uncommitted) frame at its tail, and the scalar status.
  ent_t mq0[$];
  ent_t mq1[$];
  int   m_open  [2];
  int   m_frames[2];
  bit   m_ovf   [2];
  bit   m_udf   [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 0; m_frames[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    ent_t q[$];
    int   vis;
    bit   emp, ful;
    ent_t head;
    if (!clk_en) return;
    if (k == 0) q = mq0; else q = mq1;
    if (clr) begin
      q.delete();
      m_open[k] = 0; m_frames[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
    end else begin
      vis  = (k == 1) ? q.size() - m_open[k] : q.size();
      emp  = (vis == 0);
      ful  = (q.size() == DEPTH);
      head = emp ? '0 : q[0];
      if (wdrop && k == 1) begin
        for (int i = 0; i < m_open[k]; i++) q.delete(q.size() - 1);
        m_open[k] = 0;
      end else if (wen) begin
        if (ful) m_ovf[k] = 1;
        else begin
          q.push_back({wlast, wctrl, wdata});
          if (wlast) begin m_open[k] = 0; m_frames[k]++; end
          else m_open[k]++;
        end
      end
      if (ren) begin
        if (emp) m_udf[k] = 1;
        else begin
          q.delete(0);
          if (head[36]) m_frames[k]--;
        end
      end
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      ent_t q[$];
      int   vis;
      if (k == 0) q = mq0; else q = mq1;
      vis = (k == 1) ? q.size() - m_open[k] : q.size();
      check($sformatf("empty%0d", k),  64'(s_empty[k]),  64'(vis == 0));
      check($sformatf("full%0d", k),   64'(s_full[k]),   64'(q.size() == DEPTH));
      check($sformatf("afull%0d", k),  64'(s_afull[k]),  64'(q.size() >= DEPTH - 4));
      check($sformatf("level%0d", k),  64'(s_level[k]),  64'(q.size()));
      check($sformatf("frames%0d", k), 64'(s_frames[k]), 64'(m_frames[k]));
      check($sformatf("ovf%0d", k),    64'(s_ovf[k]),    64'(m_ovf[k]));
      check($sformatf("udf%0d", k),    64'(s_udf[k]),    64'(m_udf[k]));
      if (vis > 0) begin
        check($sformatf("rlast%0d", k), 64'(s_rlast[k]), 64'(q[0][36]));
        check($sformatf("rctrl%0d", k), 64'(s_rctrl[k]), 64'(q[0][35:32]));
        check($sformatf("rdata%0d", k), 64'(s_rdata[k]), 64'(q[0][31:0]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle();
    clk_en = 1'b1; clr = 1'b0; wen = 1'b0; wlast = 1'b0;
    wdrop = 1'b0; ren = 1'b0; wctrl = '0; wdata = '0;
  endtask

  task automatic do_write(input bit last);
    wen = 1'b1; wlast = last;
    wctrl = 4'($urandom); wdata = $urandom;
    tick();
    wen = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_read();
    ren = 1'b1;
    tick();
    ren = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    // Asynchronous reset: outputs must clear before any clock edge.
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst_empty", 64'(s_empty[0]), 64'(1));
    check("rst_level", 64'(s_level[0]), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to full with 4-entry frames; almost-full first at level 12.
    for (int i = 0; i < 16; i++) begin
      do_write(i % 4 == 3);
      if (i == 10) check("afull_below", 64'(s_afull[0]), 64'(0));
      if (i == 11) check("afull_at12",  64'(s_afull[0]), 64'(1));
    end
    check("full16",  64'(s_full[0]),  64'(1));
    check("level16", 64'(s_level[0]), 64'(16));
    do_write(1'b1);
    check("ovf17",    64'(s_ovf[0]),   64'(1));
    check("level17",  64'(s_level[0]), 64'(16));
    check("frames17", 64'(s_frames[0]), 64'(4));
    repeat (16) do_read();
    check("drained", 64'(s_empty[0]), 64'(1));

    // Four complete frames plus an open one, then flush.
    for (int f = 0; f < 4; f++) begin
      do_write(1'b0);
      do_write(1'b1);
    end
    do_write(1'b0);
    check("pre_clr_frames", 64'(s_frames[1]), 64'(4));
    check("pre_clr_ovf",    64'(s_ovf[1]),    64'(1));
    do_clr();
    check("clr_level",  64'(s_level[0]),  64'(0));
    check("clr_frames", 64'(s_frames[1]), 64'(0));
    check("clr_ovf",    64'(s_ovf[0]),    64'(0));
    check("clr_empty",  64'(s_empty[1]),  64'(1));
    do_read();
    check("udf_set", 64'(s_udf[0]), 64'(1));
    do_clr();

    // Wrap: 10 in, 10 out, twice; pointers end at 20 (wrap bit set).
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) do_write(i == 9);
      repeat (10) do_read();
    end
    check("wptr_msb", 64'(u_dut0.r_wptr[4]), 64'(1));
    check("rptr_msb", 64'(u_dut0.r_rptr[4]), 64'(1));
    check("wrap_empty", 64'(s_empty[0]), 64'(1));

    // Concurrent read and write at level 5.
    for (int i = 0; i < 5; i++) do_write(1'b1);
    wen = 1'b1; wlast = 1'b1; ren = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wctrl = 4'($urandom); wdata = $urandom;
      tick();
      check("level_hold", 64'(s_level[0]), 64'(5));
    end
    idle();
    repeat (5) do_read();

    // Store-and-forward: a frame is invisible until its last entry.
    repeat (3) do_write(1'b0);
    check("sf_hidden", 64'(s_empty[1]), 64'(1));
    check("sf_level3", 64'(s_level[1]), 64'(3));
    do_write(1'b1);
    check("sf_visible", 64'(s_empty[1]),  64'(0));
    check("sf_frames1", 64'(s_frames[1]), 64'(1));
    repeat (4) do_read();

    // Drop an open 2-entry frame, then a 2-entry frame reads back intact.
    do_clr();
    repeat (2) do_write(1'b0);
    wdrop = 1'b1;
    tick();
    wdrop = 1'b0;
    check("drop_level", 64'(s_level[1]), 64'(0));
    check("drop_empty", 64'(s_empty[1]), 64'(1));
    do_write(1'b0);
    do_write(1'b1);
    check("frm_e1_last", 64'(s_rlast[1]), 64'(0));
    do_read();
    check("frm_e2_last", 64'(s_rlast[1]), 64'(1));
    do_read();
    do_clr();

    // Clock enable low: arbitrary requests must change nothing.
    repeat (3) do_write(1'b1);
    clk_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {clr, wen, wlast, wdrop, ren} = 5'($urandom);
      wctrl = 4'($urandom); wdata = $urandom;
      tick();
    end
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      wdrop  = ($urandom_range(0, 29) == 0);
      wen    = ($urandom_range(0, 9) < 6);
      wlast  = ($urandom_range(0, 9) < 3);
      ren    = ($urandom_range(0, 9) < 5);
      wctrl  = 4'($urandom);
      wdata  = $urandom;
      tick();
    end
    idle();

    // Reset in the middle of a frame discards everything asynchronously.
    do_clr();
    do_write(1'b1);
    repeat (2) do_write(1'b0);
    wen = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("mid_rst_level", 64'(s_level[1]), 64'(0));
    @(posedge clk);
    #1;
    compare_all();
    wen = 1'b0;
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mac_tx_fifo
`default_nettype wire
